// File: rtl/crc8_pkg.sv
// Shared types, constants and the single-bit CRC8 update used by the frame serialiser.
package crc8_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned CNT_W  = 3;

   localparam logic [BYTE_W-1:0] CRC8_POLY = 8'h2F;
   localparam logic [BYTE_W-1:0] CRC8_INIT = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_CRC  = 2'd2
   } ser_st_e;

   // One buffered frame byte together with its end-of-frame flag
   typedef struct packed {
      logic              last;
      logic [BYTE_W-1:0] data;
   } byte_ent_t;

   // MSB-first CRC8 update for one data bit; bit 0 of the polynomial is the feedback itself
   function automatic logic [BYTE_W-1:0] crc8_step(input logic [BYTE_W-1:0] c, input logic d);
      logic fb;
      fb = c[BYTE_W-1] ^ d;
      return {c[BYTE_W-2:0], fb} ^ (fb ? (CRC8_POLY & 8'hFE) : 8'h00);
   endfunction

endpackage

// File: rtl/crc8_frame_ser_if.sv
// Byte handshake between the frame builder (master) and the CRC8 frame serialiser (slave).
interface crc8_frame_ser_if;

   logic       i_byte_vld;
   logic [7:0] i_byte;
   logic       i_byte_last;
   logic       o_byte_rdy;

   modport master (
      output i_byte_vld,
      output i_byte,
      output i_byte_last,
      input  o_byte_rdy
   );

   modport slave (
      input  i_byte_vld,
      input  i_byte,
      input  i_byte_last,
      output o_byte_rdy
   );

endinterface

// File: rtl/crc8_byte_buf.sv
// Single-entry valid/ready skid for frame bytes; ready simply means the entry is empty.
module crc8_byte_buf
   import crc8_pkg::*;
(
   input  logic      i_clk,
   input  logic      i_rst,
   input  logic      i_push_vld,
   input  byte_ent_t i_ent,
   output logic      o_rdy,
   input  logic      i_pop,
   output logic      o_full,
   output byte_ent_t o_ent
);

   logic      empty_q;
   byte_ent_t ent_q;
   logic      push;

   assign push = i_push_vld & empty_q;

   // Empty flag is kept directly so ready leaves the block straight from a flop
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         empty_q <= 1'b1;
         ent_q   <= '0;
      end else begin
         if (push) begin
            ent_q <= i_ent;
         end
         empty_q <= ~(push | (~empty_q & ~i_pop));
      end
   end

   assign o_rdy  = empty_q;
   assign o_full = ~empty_q;
   assign o_ent  = ent_q;

endmodule

// File: rtl/crc8_frame_ser.sv
// Serialises frame bytes MSB-first on a bit-rate tick and appends the running CRC8 of the frame.
module crc8_frame_ser
   import crc8_pkg::*;
#(
   parameter logic              IDLE_LVL = 1'b1,
   parameter logic [BYTE_W-1:0] CRC_INIT = CRC8_INIT
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_bit_en,
   crc8_frame_ser_if.slave    bif,
   output logic               o_sdo,
   output logic               o_sdo_vld,
   output logic               o_busy,
   output logic               o_underrun,
   output logic               o_done,
   output logic [BYTE_W-1:0]  o_crc
);

   ser_st_e           state_q,   state_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [BYTE_W-1:0] sh_q,      sh_d;
   logic              sh_vld_q,  sh_vld_d;
   logic              sh_last_q, sh_last_d;
   logic [BYTE_W-1:0] crc_q,     crc_d;
   logic [BYTE_W-1:0] crc_tx_q,  crc_tx_d;
   logic              sdo_q,     sdo_d;
   logic              sdo_vld_q, sdo_vld_d;
   logic              und_q,     und_d;
   logic              done_q,    done_d;
   logic              busy_q,    busy_d;
   logic [BYTE_W-1:0] crc_out_q, crc_out_d;

   byte_ent_t in_ent;
   byte_ent_t buf_ent;
   logic      buf_full;
   logic      buf_pop;

   assign in_ent = '{last: bif.i_byte_last, data: bif.i_byte};

   crc8_byte_buf u_buf (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_push_vld (bif.i_byte_vld),
      .i_ent      (in_ent),
      .o_rdy      (bif.o_byte_rdy),
      .i_pop      (buf_pop),
      .o_full     (buf_full),
      .o_ent      (buf_ent)
   );

   // Bit source for a DATA tick: the shift register, or the buffer straight after an underrun wait
   logic              src_vld;
   logic [BYTE_W-1:0] src_byte;
   logic              src_last;
   logic [CNT_W-1:0]  src_cnt;
   logic [BYTE_W-1:0] crc_nxt;

   assign src_vld  = sh_vld_q | buf_full;
   assign src_byte = sh_vld_q ? sh_q      : buf_ent.data;
   assign src_last = sh_vld_q ? sh_last_q : buf_ent.last;
   assign src_cnt  = sh_vld_q ? bit_cnt_q : CNT_W'(7);
   assign crc_nxt  = crc8_step(crc_q, src_byte[BYTE_W-1]);

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      sh_d      = sh_q;
      sh_vld_d  = sh_vld_q;
      sh_last_d = sh_last_q;
      crc_d     = crc_q;
      crc_tx_d  = crc_tx_q;
      sdo_d     = sdo_q;
      sdo_vld_d = 1'b0;
      und_d     = 1'b0;
      done_d    = 1'b0;
      crc_out_d = crc_out_q;
      buf_pop   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            sdo_d = IDLE_LVL;
            if (buf_full) begin
               buf_pop   = 1'b1;
               sh_d      = buf_ent.data;
               sh_last_d = buf_ent.last;
               sh_vld_d  = 1'b1;
               bit_cnt_d = CNT_W'(7);
               crc_d     = CRC_INIT;
               state_d   = ST_DATA;
            end
         end

         ST_DATA: begin
            // Refill an empty shift register between ticks; a tick below overrides this
            if (!sh_vld_q && buf_full) begin
               buf_pop   = 1'b1;
               sh_d      = buf_ent.data;
               sh_last_d = buf_ent.last;
               sh_vld_d  = 1'b1;
               bit_cnt_d = CNT_W'(7);
            end
            if (i_bit_en) begin
               if (src_vld) begin
                  sdo_d     = src_byte[BYTE_W-1];
                  sdo_vld_d = 1'b1;
                  crc_d     = crc_nxt;
                  sh_d      = {src_byte[BYTE_W-2:0], 1'b0};
                  sh_last_d = src_last;
                  sh_vld_d  = 1'b1;
                  bit_cnt_d = src_cnt - CNT_W'(1);
                  if (src_cnt == '0) begin
                     if (src_last) begin
                        sh_vld_d  = 1'b0;
                        bit_cnt_d = CNT_W'(7);
                        crc_tx_d  = crc_nxt;
                        state_d   = ST_CRC;
                     end else if (buf_full) begin
                        buf_pop   = 1'b1;
                        sh_d      = buf_ent.data;
                        sh_last_d = buf_ent.last;
                        bit_cnt_d = CNT_W'(7);
                     end else begin
                        sh_vld_d = 1'b0;
                     end
                  end
               end else begin
                  und_d = 1'b1;
                  sdo_d = IDLE_LVL;
               end
            end
         end

         ST_CRC: begin
            if (i_bit_en) begin
               sdo_d     = crc_tx_q[BYTE_W-1];
               sdo_vld_d = 1'b1;
               crc_tx_d  = {crc_tx_q[BYTE_W-2:0], 1'b0};
               bit_cnt_d = bit_cnt_q - CNT_W'(1);
               if (bit_cnt_q == '0) begin
                  crc_out_d = crc_q;
                  done_d    = 1'b1;
                  state_d   = ST_IDLE;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         sh_q      <= '0;
         sh_vld_q  <= 1'b0;
         sh_last_q <= 1'b0;
         crc_q     <= CRC_INIT;
         crc_tx_q  <= '0;
         sdo_q     <= IDLE_LVL;
         sdo_vld_q <= 1'b0;
         und_q     <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         crc_out_q <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         sh_q      <= sh_d;
         sh_vld_q  <= sh_vld_d;
         sh_last_q <= sh_last_d;
         crc_q     <= crc_d;
         crc_tx_q  <= crc_tx_d;
         sdo_q     <= sdo_d;
         sdo_vld_q <= sdo_vld_d;
         und_q     <= und_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
         crc_out_q <= crc_out_d;
      end
   end

   assign o_sdo      = sdo_q;
   assign o_sdo_vld  = sdo_vld_q;
   assign o_busy     = busy_q;
   assign o_underrun = und_q;
   assign o_done     = done_q;
   assign o_crc      = crc_out_q;

endmodule

// File: tb/tb_crc8_frame_ser.sv
// Directed bench for crc8_frame_ser: known CRC vectors, back-to-back frames, stalls, reset abort.
module tb_crc8_frame_ser;

   logic       clk;
   logic       rst;
   logic       bit_en;
   logic       sdo;
   logic       sdo_vld;
   logic       busy;
   logic       und;
   logic       done;
   logic [7:0] crc;

   crc8_frame_ser_if bif ();

   crc8_frame_ser #(
      .IDLE_LVL (1'b1),
      .CRC_INIT (8'hFF)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_bit_en   (bit_en),
      .bif        (bif),
      .o_sdo      (sdo),
      .o_sdo_vld  (sdo_vld),
      .o_busy     (busy),
      .o_underrun (und),
      .o_done     (done),
      .o_crc      (crc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   bit         bits[$];
   logic [7:0] crcs[$];
   int         n_und  = 0;
   int         n_done = 0;
   int         n_gap  = 0;
   bit         exp_bits[$];
   logic [7:0] exp_crcs[$];

   // Observers: serial bits, pulses and frame-start cycles with no bit on the line
   always @(negedge clk) begin
      if (!rst) begin
         if (sdo_vld) bits.push_back(sdo);
         if (und) n_und <= n_und + 1;
         if (done) begin
            n_done <= n_done + 1;
            crcs.push_back(crc);
         end
         if (busy && !sdo_vld) n_gap <= n_gap + 1;
      end
   end

   int tick_period = 0;
   bit tick_rand   = 1'b0;
   int tcnt        = 0;

   initial begin
      bit_en = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (tick_period == 0) begin
            bit_en = 1'b0;
         end else if (tick_rand) begin
            bit_en = 1'($urandom_range(0, 1));
         end else begin
            tcnt = tcnt + 1;
            if (tcnt >= tick_period) begin
               tcnt   = 0;
               bit_en = 1'b1;
            end else begin
               bit_en = 1'b0;
            end
         end
      end
   end

   function automatic logic [7:0] ref_crc(input logic [7:0] q[$]);
      logic [7:0] c;
      logic [7:0] b;
      c = 8'hFF;
      foreach (q[i]) begin
         b = q[i];
         for (int k = 7; k >= 0; k--) begin
            if (c[7] ^ b[k]) c = {c[6:0], 1'b0} ^ 8'h2F;
            else             c = {c[6:0], 1'b0};
         end
      end
      return c;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic add_frame(input logic [7:0] q[$]);
      logic [7:0] c;
      logic [7:0] b;
      c = ref_crc(q);
      foreach (q[i]) begin
         b = q[i];
         for (int k = 7; k >= 0; k--) exp_bits.push_back(b[k]);
      end
      for (int k = 7; k >= 0; k--) exp_bits.push_back(c[k]);
      exp_crcs.push_back(c);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last, input bit keep_vld);
      int n;
      bit r;
      @(posedge clk);
      #1;
      bif.i_byte_vld  = 1'b1;
      bif.i_byte      = b;
      bif.i_byte_last = last;
      n = 0;
      r = 1'b0;
      while (!r && n < 2000) begin
         @(negedge clk);
         r = bif.o_byte_rdy;
         @(posedge clk);
         n++;
      end
      if (!r) chk("send_timeout", 32'(r), 32'd1);
      #1;
      if (!keep_vld) bif.i_byte_vld = 1'b0;
   endtask

   task automatic wait_done(input int target, input string tag);
      int n;
      n = 0;
      while (n_done < target && n < 5000) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk(tag, 32'(n_done >= target), 32'd1);
   endtask

   task automatic chk_stream(input string tag, input int base);
      int mism;
      mism = 0;
      chk({tag, "_len"}, 32'(bits.size() - base), 32'(exp_bits.size()));
      foreach (exp_bits[i]) begin
         if (base + i >= bits.size()) mism++;
         else if (bits[base + i] !== exp_bits[i]) mism++;
      end
      chk(tag, 32'(mism), 32'd0);
   endtask

   task automatic settle();
      repeat (3) @(negedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] q[$];
      logic [7:0] fq[$];
      logic [15:0] w;
      int base;
      int d0;
      int u0;
      int g0;
      int c0;
      int n;
      int len;

      rst             = 1'b1;
      bif.i_byte_vld  = 1'b0;
      bif.i_byte      = 8'h00;
      bif.i_byte_last = 1'b0;
      tick_period     = 1;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_sdo",     32'(sdo),            32'd1);
      chk("rst_crc",     32'(crc),            32'h00);
      chk("rst_rdy",     32'(bif.o_byte_rdy), 32'd1);
      chk("rst_busy",    32'(busy),           32'd0);
      chk("rst_sdo_vld", 32'(sdo_vld),        32'd0);
      chk("rst_pulses",  32'({done, und}),    32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      chk("idle_ticks_ignored", 32'(bits.size()), 32'd0);

      // Single 0x00 byte at full rate
      base = bits.size();
      d0   = n_done;
      u0   = n_und;
      send_byte(8'h00, 1'b1, 1'b0);
      wait_done(d0 + 1, "t1_done_timeout");
      settle();
      chk("t1_crc",    32'(crc),                32'h42);
      chk("t1_ndone",  32'(n_done - d0),        32'd1);
      chk("t1_nbits",  32'(bits.size() - base), 32'd16);
      w = '0;
      for (int i = 0; i < 16; i++) if (base + i < bits.size()) w = {w[14:0], 1'(bits[base + i])};
      chk("t1_stream", 32'(w),                  32'h0042);
      chk("t1_und",    32'(n_und - u0),         32'd0);
      chk("t1_idle",   32'({busy, sdo}),        32'b01);

      // "123456789" with a tick every 4 cycles
      tick_period = 4;
      base = bits.size();
      d0   = n_done;
      u0   = n_und;
      q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      exp_bits.delete();
      add_frame(q);
      foreach (q[i]) send_byte(q[i], 1'(i == 8), 1'b0);
      wait_done(d0 + 1, "t2_done_timeout");
      settle();
      chk("t2_crc",   32'(crc),                32'h20);
      chk("t2_nbits", 32'(bits.size() - base), 32'd80);
      chk("t2_und",   32'(n_und - u0),         32'd0);
      chk_stream("t2_stream", base);

      // Back-to-back frames at full rate, valid held high
      tick_period = 1;
      base = bits.size();
      d0   = n_done;
      g0   = n_gap;
      c0   = crcs.size();
      exp_bits.delete();
      fq = '{8'h00};
      add_frame(fq);
      add_frame(q);
      send_byte(8'h00, 1'b1, 1'b1);
      foreach (q[i]) send_byte(q[i], 1'(i == 8), 1'(i != 8));
      wait_done(d0 + 2, "t3_done_timeout");
      settle();
      chk("t3_ndone", 32'(n_done - d0), 32'd2);
      if (crcs.size() >= c0 + 2) begin
         chk("t3_crc0", 32'(crcs[c0]),     32'h42);
         chk("t3_crc1", 32'(crcs[c0 + 1]), 32'h20);
      end else begin
         chk("t3_crc_count", 32'(crcs.size() - c0), 32'd2);
      end
      chk("t3_gaps", 32'(n_gap - g0), 32'd2);
      chk_stream("t3_stream", base);

      // Byte source stalls for 3 ticks inside a 2-byte frame
      tick_period = 4;
      base = bits.size();
      d0   = n_done;
      u0   = n_und;
      exp_bits.delete();
      fq = '{8'h31, 8'h32};
      add_frame(fq);
      send_byte(8'h31, 1'b0, 1'b0);
      n = 0;
      while (n_und - u0 < 3 && n < 2000) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("t4_stall_timeout", 32'(n_und - u0 >= 3), 32'd1);
      send_byte(8'h32, 1'b1, 1'b0);
      wait_done(d0 + 1, "t4_done_timeout");
      settle();
      chk("t4_und", 32'(n_und - u0), 32'd3);
      chk("t4_crc", 32'(crc),        32'(ref_crc(fq)));
      chk_stream("t4_stream", base);

      // Reset mid-frame aborts without o_done
      tick_period = 1;
      base = bits.size();
      d0   = n_done;
      send_byte(8'hA5, 1'b1, 1'b0);
      n = 0;
      while (bits.size() - base < 5 && n < 2000) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("t5_bits_timeout", 32'(bits.size() - base >= 5), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("t5_rst_state", 32'({busy, sdo, bif.o_byte_rdy}), 32'b011);
      chk("t5_rst_crc",   32'(crc), 32'h00);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      chk("t5_abort_no_done", 32'(n_done - d0), 32'd0);
      base = bits.size();
      send_byte(8'h00, 1'b1, 1'b0);
      wait_done(d0 + 1, "t5_done_timeout");
      settle();
      chk("t5_crc",   32'(crc),                32'h42);
      chk("t5_ndone", 32'(n_done - d0),        32'd1);
      chk("t5_nbits", 32'(bits.size() - base), 32'd16);

      // Random frames, random tick density and byte gaps
      tick_rand = 1'b1;
      base = bits.size();
      d0   = n_done;
      c0   = crcs.size();
      exp_bits.delete();
      exp_crcs.delete();
      for (int f = 0; f < 20; f++) begin
         fq.delete();
         len = int'($urandom_range(1, 4));
         for (int i = 0; i < len; i++) fq.push_back(8'($urandom_range(0, 255)));
         add_frame(fq);
         foreach (fq[i]) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            send_byte(fq[i], 1'(i == len - 1), 1'b0);
         end
      end
      wait_done(d0 + 20, "t6_done_timeout");
      settle();
      chk("t6_ndone", 32'(n_done - d0), 32'd20);
      foreach (exp_crcs[i]) begin
         if (c0 + i < crcs.size()) chk("t6_crc", 32'(crcs[c0 + i]), 32'(exp_crcs[i]));
      end
      chk_stream("t6_stream", base);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
